// File: rtl/ntt_intt_iter.sv
// Iterative in-place radix-2 Gentleman-Sande NTT/INTT engine with streaming load and unload.
// Define NTT_INTT_SCALE_EN to add the D^-1 scaling pass after an inverse transform.
module ntt_intt_iter #(
  parameter int D         = 8,
  parameter int W         = 5,
  parameter int Q         = 17,
  parameter int OMEGA     = 2,
  parameter int OMEGA_INV = 9
`ifdef NTT_INTT_SCALE_EN
  ,
  parameter int D_INV     = 15
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic         done
);

  localparam int LOGD = $clog2(D);
  localparam int SW   = (LOGD > 1) ? $clog2(LOGD) : 1;

  localparam logic [W:0]      Q1        = (W+1)'(Q);
  localparam logic [2*W-1:0]  Q2        = (2*W)'(Q);
  localparam logic [W-1:0]    R_FWD     = W'(OMEGA);
  localparam logic [W-1:0]    R_INV     = W'(OMEGA_INV);
  localparam logic [W-1:0]    ONE       = W'(1);
  localparam logic [LOGD-1:0] HALF_MAX  = LOGD'(D / 2);
  localparam logic [LOGD-1:0] K_LAST    = LOGD'(D / 2 - 1);
  localparam logic [LOGD-1:0] CNT_LAST  = LOGD'(D - 1);
  localparam logic [SW-1:0]   STG_LAST  = SW'(LOGD - 1);
`ifdef NTT_INTT_SCALE_EN
  localparam logic [W-1:0]    DINV_C    = W'(D_INV);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    COMP   = 3'd2,
`ifdef NTT_INTT_SCALE_EN
    SCALE  = 3'd3,
`endif
    UNLOAD = 3'd4
  } state_t;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= Q1) sum = sum - Q1;
    return W'(sum);
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] diff;
    if (a >= b) diff = {1'b0, a} - {1'b0, b};
    else        diff = {1'b0, a} + Q1 - {1'b0, b};
    return W'(diff);
  endfunction

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    logic [2*W-1:0] rem;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    rem  = prod % Q2;
    return W'(rem);
  endfunction

  function automatic logic [LOGD-1:0] bitrev(input logic [LOGD-1:0] x);
    logic [LOGD-1:0] r;
    for (int b = 0; b < LOGD; b++) r[b] = x[LOGD-1-b];
    return r;
  endfunction

  state_t          state;
  logic [LOGD-1:0] cnt;
  logic [SW-1:0]   stage;
  logic            mode_r;
  logic [W-1:0]    ws;
  logic [W-1:0]    w;
  logic [W-1:0]    mem [D];

  logic [LOGD-1:0] half;
  logic [LOGD-1:0] mask;
  logic [LOGD-1:0] idx_lo;
  logic [LOGD-1:0] idx_hi;
  logic [LOGD-1:0] knext;
  logic            jnext_zero;
  logic [W-1:0]    a;
  logic [W-1:0]    b;

  // During COMP cnt is the butterfly index k; split it into group and offset j around half.
  always_comb begin
    half       = HALF_MAX >> stage;
    mask       = half - 1'b1;
    idx_lo     = ((cnt & ~mask) << 1) | (cnt & mask);
    idx_hi     = idx_lo | half;
    knext      = cnt + 1'b1;
    jnext_zero = ((knext & mask) == '0);
    a          = mem[idx_lo];
    b          = mem[idx_hi];
  end

  assign out_data = out_valid ? mem[bitrev(cnt)] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stage     <= '0;
      mode_r    <= 1'b0;
      ws        <= '0;
      w         <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            mode_r   <= mode;
            cnt      <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end

        LOAD: begin
          if (in_valid) begin
            mem[cnt] <= in_data;
            cnt      <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state    <= COMP;
              in_ready <= 1'b0;
              stage    <= '0;
              ws       <= mode_r ? R_INV : R_FWD;
              w        <= ONE;
            end
          end
        end

        // One butterfly per cycle; w tracks ws^j and restarts at 1 whenever j wraps.
        COMP: begin
          mem[idx_lo] <= mod_add(a, b);
          mem[idx_hi] <= mod_mul(mod_sub(a, b), w);
          w           <= jnext_zero ? ONE : mod_mul(w, ws);
          if (cnt == K_LAST) begin
            cnt   <= '0;
            stage <= stage + 1'b1;
            ws    <= mod_mul(ws, ws);
            if (stage == STG_LAST) begin
              stage <= '0;
`ifdef NTT_INTT_SCALE_EN
              if (mode_r) begin
                state <= SCALE;
              end else begin
                state     <= UNLOAD;
                out_valid <= 1'b1;
              end
`else
              state     <= UNLOAD;
              out_valid <= 1'b1;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef NTT_INTT_SCALE_EN
        SCALE: begin
          mem[cnt] <= mod_mul(mem[cnt], DINV_C);
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= UNLOAD;
            out_valid <= 1'b1;
          end
        end
`endif

        UNLOAD: begin
          if (out_ready) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_intt_iter.sv
// Directed self-checking bench for ntt_intt_iter (D=8, Q=17); honours NTT_INTT_SCALE_EN.
module tb_ntt_intt_iter;

  localparam int D = 8;
  localparam int W = 5;
  localparam int NTT_LAT = 13;
`ifdef NTT_INTT_SCALE_EN
  localparam int INTT_LAT = 21;
`else
  localparam int INTT_LAT = 13;
`endif

  typedef int vec_t [D];

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;
  int doneCount   = 0;
  int busyLowCnt  = 0;
  bit inTxn       = 1'b0;

  vec_t onesV    = '{1, 1, 1, 1, 1, 1, 1, 1};
  vec_t impulseV = '{1, 0, 0, 0, 0, 0, 0, 0};
  vec_t shiftV   = '{0, 1, 0, 0, 0, 0, 0, 0};
  vec_t powersV  = '{1, 2, 4, 8, 16, 15, 13, 9};
  vec_t dcV      = '{8, 0, 0, 0, 0, 0, 0, 0};
  vec_t xV       = '{3, 7, 0, 16, 5, 1, 2, 9};
  vec_t xHatV    = '{9, 7, 6, 0, 11, 7, 6, 12};
`ifdef NTT_INTT_SCALE_EN
  vec_t dcInvV   = '{1, 1, 1, 1, 1, 1, 1, 1};
  vec_t xBackV   = '{3, 7, 0, 16, 5, 1, 2, 9};
`else
  vec_t dcInvV   = '{8, 8, 8, 8, 8, 8, 8, 8};
  vec_t xBackV   = '{7, 5, 0, 9, 6, 8, 16, 4};
`endif

  ntt_intt_iter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Monitors run on the falling edge so they see settled post-edge values.
  always @(negedge clk) begin
    if (done) doneCount++;
    if (inTxn && !busy) busyLowCnt++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic m, input vec_t v, input bit gaps);
    int waitCycles;
    start = 1'b1;
    mode  = m;
    step();
    start = 1'b0;
    inTxn = 1'b1;
    checkOutput("load in_ready", in_ready, 1);
    for (int n = 0; n < D; n++) begin
      if (gaps && (n % 3 == 1)) begin
        in_valid = 1'b0;
        step();
      end
      waitCycles = 0;
      while (!in_ready && waitCycles < 20) begin
        step();
        waitCycles++;
      end
      in_valid = 1'b1;
      in_data  = W'(v[n]);
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic runTransaction(input string tag, input logic m, input vec_t vin, input vec_t vexp,
                                input int expLat, input bit gaps, input bit backpressure,
                                input bit strayStart);
    int lat;
    int idx;
    int cyc;
    int doneBefore;
    int busyLowBefore;
    busyLowBefore = busyLowCnt;
    doneBefore    = doneCount;
    applyStimulus(m, vin, gaps);

    // lat counts clock edges from the one that accepts the last input beat
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (strayStart && lat == 4) begin
        start = 1'b1;
        mode  = ~m;
      end
      step();
      start = 1'b0;
      lat++;
    end
    checkOutput({tag, " latency"}, lat, expLat);

    idx = 0;
    cyc = 0;
    while (idx < D && cyc < 200) begin
      out_ready = backpressure ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      checkOutput($sformatf("%s out_valid[%0d]", tag, idx), out_valid, 1);
      checkOutput($sformatf("%s out_data[%0d]", tag, idx), out_data, vexp[idx]);
      step();
      if (out_ready) idx++;
      cyc++;
    end
    out_ready = 1'b0;
    checkOutput({tag, " done pulse"}, done, 1);
    checkOutput({tag, " busy after"}, busy, 0);
    checkOutput({tag, " out_valid after"}, out_valid, 0);
    inTxn = 1'b0;
    step();
    checkOutput({tag, " done falls"}, done, 0);
    checkOutput({tag, " done count"}, doneCount - doneBefore, 1);
    checkOutput({tag, " busy held"}, busyLowCnt - busyLowBefore, 0);
  endtask

  initial begin
    int strayBeats;
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset out_data", out_data, 0);
    rst = 1'b0;
    step();

    runTransaction("ntt ones", 1'b0, onesV, dcV, NTT_LAT, 1'b0, 1'b0, 1'b0);
    runTransaction("ntt impulse", 1'b0, impulseV, onesV, NTT_LAT, 1'b0, 1'b0, 1'b0);
    runTransaction("ntt shift", 1'b0, shiftV, powersV, NTT_LAT, 1'b0, 1'b0, 1'b0);
    runTransaction("intt dc", 1'b1, dcV, dcInvV, INTT_LAT, 1'b0, 1'b0, 1'b0);
    runTransaction("ntt x bp", 1'b0, xV, xHatV, NTT_LAT, 1'b1, 1'b1, 1'b1);
    runTransaction("intt xhat", 1'b1, xHatV, xBackV, INTT_LAT, 1'b0, 1'b1, 1'b0);

    // Abort in the middle of COMP and confirm nothing is emitted afterwards.
    applyStimulus(1'b0, xV, 1'b0);
    repeat (5) step();
    inTxn = 1'b0;
    rst   = 1'b1;
    step();
    rst   = 1'b0;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort out_valid", out_valid, 0);
    checkOutput("abort in_ready", in_ready, 0);
    strayBeats = 0;
    out_ready  = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (out_valid || busy) strayBeats++;
      step();
    end
    out_ready = 1'b0;
    checkOutput("abort quiet", strayBeats, 0);

    runTransaction("ntt after abort", 1'b0, shiftV, powersV, NTT_LAT, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
